// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and receiver state type, shared by the VGA generator and receiver.
package vga_pkg;
   localparam int H_ACTIVE    = 640;
   localparam int H_FRONT     = 16;
   localparam int H_SYNC      = 96;
   localparam int H_BACK      = 48;
   localparam int H_TOTAL     = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_ACTIVE    = 480;
   localparam int V_FRONT     = 10;
   localparam int V_SYNC      = 2;
   localparam int V_BACK      = 33;
   localparam int V_TOTAL     = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int LOCK_FRAMES = 2;
   typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} rx_state_t;
endpackage

// File: rtl/vga_rx_if.sv
// vga_rx_if: incoming sync/blank/RGB stream and the recovered, coordinate-tagged pixel stream.
interface vga_rx_if;
   logic        i_hs, i_vs, i_blank_n;
   logic [7:0]  i_r, i_g, i_b;
   logic        o_valid, o_frame_start, o_line_end, o_frame_end, o_locked, o_err;
   logic [7:0]  o_r, o_g, o_b;
   logic [10:0] o_x, o_y, o_v_total;
   logic [11:0] o_h_total;
   modport master (
      output i_hs, i_vs, i_blank_n, i_r, i_g, i_b,
      input  o_valid, o_frame_start, o_line_end, o_frame_end, o_locked, o_err,
             o_r, o_g, o_b, o_x, o_y, o_h_total, o_v_total
   );
   modport slave (
      input  i_hs, i_vs, i_blank_n, i_r, i_g, i_b,
      output o_valid, o_frame_start, o_line_end, o_frame_end, o_locked, o_err,
             o_r, o_g, o_b, o_x, o_y, o_h_total, o_v_total
   );
endinterface

// File: rtl/vga_edge_det.sv
// vga_edge_det: registers one input and flags its rising and falling edges on the registered copy.
module vga_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic p;
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
         p <= 1'b0;
      end else begin
         q <= d;
         p <= q;
      end
   end
   assign rise = q & ~p;
   assign fall = ~q & p;
endmodule

// File: rtl/vga_rx.sv
// vga_rx: recovers VGA timing from a sync/blank/RGB stream, locks after consecutive matching
// frames and then emits pixels tagged with (x, y) plus frame/line markers.
module vga_rx import vga_pkg::*; #(
   parameter int H_ACT  = H_ACTIVE,
   parameter int V_ACT  = V_ACTIVE,
   parameter int H_TOT  = H_TOTAL,
   parameter int V_TOT  = V_TOTAL,
   parameter int LOCK_N = LOCK_FRAMES
) (
   input logic     clk,
   input logic     rst,
   vga_rx_if.slave vid
);
   logic        hs_q, hs_rise, hs_fall, vs_q, vs_rise, vs_fall, bn_q, bn_rise, bn_fall;
   logic [7:0]  r_q, g_q, b_q, lock_cnt;
   logic [11:0] hper;
   logic [10:0] lper, x, y;
   logic        hs_seen, frame_bad;
   logic        hs_bad, w_bad, ovf, v_bad, viol, frame_ok, pix;
   logic        unused;
   rx_state_t   state;

   vga_edge_det u_hs (.clk(clk), .rst(rst), .d(vid.i_hs),      .q(hs_q), .rise(hs_rise), .fall(hs_fall));
   vga_edge_det u_vs (.clk(clk), .rst(rst), .d(vid.i_vs),      .q(vs_q), .rise(vs_rise), .fall(vs_fall));
   vga_edge_det u_bn (.clk(clk), .rst(rst), .d(vid.i_blank_n), .q(bn_q), .rise(bn_rise), .fall(bn_fall));
   assign unused = &{hs_q, hs_rise, vs_q, vs_rise, bn_rise};

   assign hs_bad   = hs_fall & hs_seen & (hper != 12'(H_TOT));
   assign w_bad    = bn_fall & (x != 11'(H_ACT));
   assign ovf      = bn_q & (x == 11'(H_ACT));
   assign v_bad    = vs_fall & ((lper != 11'(V_TOT)) | (y != 11'(V_ACT)));
   assign viol     = hs_bad | w_bad | ovf | v_bad;
   // A coincident HS fall belongs to the new frame, so its period error is not charged here.
   assign frame_ok = ~frame_bad & ~w_bad & ~ovf & ~v_bad;
   assign pix      = (state == S_LOCKED) & ~viol & bn_q & (x < 11'(H_ACT)) & (y < 11'(V_ACT));

   always_ff @(posedge clk) begin
      if (rst) begin
         {r_q, g_q, b_q} <= '0;
         hper            <= '0;
         lper            <= '0;
         x               <= '0;
         y               <= '0;
         hs_seen         <= 1'b0;
         frame_bad       <= 1'b0;
         vid.o_h_total   <= '0;
         vid.o_v_total   <= '0;
      end else begin
         {r_q, g_q, b_q} <= {vid.i_r, vid.i_g, vid.i_b};
         hper            <= hs_fall ? 12'd1 : hper + {11'd0, hper != '1};
         lper            <= vs_fall ? {10'd0, hs_fall} : (hs_fall && lper != '1) ? lper + 11'd1 : lper;
         x               <= bn_fall ? '0 : (bn_q && x != '1) ? x + 11'd1 : x;
         y               <= vs_fall ? '0 : (bn_fall && y != '1) ? y + 11'd1 : y;
         hs_seen         <= hs_seen | hs_fall;
         frame_bad       <= vs_fall ? hs_bad : frame_bad | hs_bad | w_bad | ovf;
         vid.o_h_total   <= (hs_fall && hs_seen) ? hper : vid.o_h_total;
         vid.o_v_total   <= vs_fall ? lper : vid.o_v_total;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_SEARCH;
         lock_cnt          <= '0;
         vid.o_locked      <= 1'b0;
         vid.o_err         <= 1'b0;
         vid.o_valid       <= 1'b0;
         {vid.o_r, vid.o_g, vid.o_b} <= '0;
         vid.o_x           <= '0;
         vid.o_y           <= '0;
         vid.o_frame_start <= 1'b0;
         vid.o_line_end    <= 1'b0;
         vid.o_frame_end   <= 1'b0;
      end else begin
         vid.o_err <= 1'b0;
         if (state == S_SEARCH) begin
            if (vs_fall) begin
               state    <= S_CHECK;
               lock_cnt <= '0;
            end
         end else if (state == S_CHECK) begin
            if (vs_fall) begin
               lock_cnt <= frame_ok ? lock_cnt + 8'd1 : 8'd0;
               if (frame_ok && lock_cnt + 8'd1 == 8'(LOCK_N)) begin
                  state        <= S_LOCKED;
                  vid.o_locked <= 1'b1;
               end
            end
         end else if (state == S_LOCKED) begin
            if (viol) begin
               state        <= S_CHECK;
               lock_cnt     <= '0;
               vid.o_err    <= 1'b1;
               vid.o_locked <= 1'b0;
            end
         end else begin
            state <= S_SEARCH;
         end
         vid.o_valid       <= pix;
         {vid.o_r, vid.o_g, vid.o_b} <= pix ? {r_q, g_q, b_q} : 24'd0;
         vid.o_x           <= pix ? x : '0;
         vid.o_y           <= pix ? y : '0;
         vid.o_frame_start <= pix && x == '0 && y == '0;
         vid.o_line_end    <= pix && x == 11'(H_ACT - 1);
         vid.o_frame_end   <= pix && x == 11'(H_ACT - 1) && y == 11'(V_ACT - 1);
      end
   end
endmodule
